// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the sequencer and the stages.
// master: stall/flush/new_pc out, requests in; slave: the reverse.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    input  stallreq_if,
    input  stallreq_id,
    input  stallreq_ex,
    input  stallreq_mem,
    input  excepttype,
    input  cp0_epc,
    output stall,
    output flush,
    output new_pc
  );

  modport slave (
    output stallreq_if,
    output stallreq_id,
    output stallreq_ex,
    output stallreq_mem,
    output excepttype,
    output cp0_epc,
    input  stall,
    input  flush,
    input  new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception freeze/flush, watchdog, perf counter.
// Ports: clk, rst, bus (pipe_ctrl_if.master), wdog_fire, stall_cnt, stall_cnt_clr.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040,
  parameter int          WDOG_LIMIT  = 1024,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus,
  output logic        wdog_fire,
  output logic [31:0] stall_cnt,
  input  logic        stall_cnt_clr
);

  localparam int WW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] WLAST = WW'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] tgt_q;
  logic [31:0] tgt_d;
  logic [WW-1:0] wdog_q;
  logic [WW-1:0] wdog_d;
  logic [31:0] stall_cnt_q;
  logic [5:0]  req_stall;
  logic [5:0]  stall_c;
  logic        fire;
  logic        exc;

  assign exc = (bus.excepttype != 32'd0);

  // Deepest requesting stage wins; it stops itself and all upstream.
  always_comb begin
    req_stall = 6'b000000;
    if (bus.stallreq_mem)
      req_stall = 6'b011111;
    else if (bus.stallreq_ex)
      req_stall = 6'b001111;
    else if (bus.stallreq_id)
      req_stall = 6'b000111;
    else if (bus.stallreq_if)
      req_stall = 6'b000011;
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    wdog_d  = '0;
    stall_c = 6'b000000;
    fire    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (exc) begin
          // Exception outranks both stalls and a coincident watchdog.
          stall_c = 6'b111111;
          state_d = FREEZE;
          if (bus.excepttype == ERET_CODE)
            tgt_d = bus.cp0_epc;
          else
            tgt_d = EXC_VECTOR;
        end else begin
          stall_c = req_stall;
          if (req_stall != 6'b000000) begin
            if (wdog_q == WLAST) begin
              fire    = 1'b1;
              tgt_d   = WDOG_VECTOR;
              state_d = FREEZE;
            end else begin
              wdog_d = wdog_q + 1'b1;
            end
          end
        end
      end
      FREEZE: begin
        stall_c = 6'b111111;
        state_d = FLUSH;
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tgt_q   <= 32'd0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      wdog_q  <= wdog_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr)
      stall_cnt_q <= 32'd0;
    else if (stall_c[0] && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  // flush/new_pc come only from registered state.
  assign bus.stall  = stall_c;
  assign bus.flush  = (state_q == FLUSH);
  assign bus.new_pc = (state_q == FLUSH) ? tgt_q : 32'd0;
  assign wdog_fire  = fire;
  assign stall_cnt  = stall_cnt_q;

endmodule
